sprite_spi_master: RTL and testbench

//  SPI initiator (mode 0, MSB first) driving the sprite chip's SPI target: spi_cs, spi_sclk, spi_mosi out, spi_miso in.

---
 rtl/sprite_spi_pkg.sv | 17 +
 rtl/sprite_spi_tick.sv | 34 +++
 rtl/sprite_spi_master.sv | 178 +++++++++++++++++
 tb/tb_sprite_spi_master.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_spi_pkg.sv
// Shared types and constants for the sprite-chip SPI initiator.
package sprite_spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    TEARDOWN,
    GAP
  } state_t;

endpackage

// File: rtl/sprite_spi_tick.sv
// Reloadable down-counter pacing SCLK half-periods and the chip-select gap.
module sprite_spi_tick
  import sprite_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_gap,
  output logic tick
);

  localparam int MAX_COUNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count;

  // NOTE: clocked state is only ever assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_gap ? CW'(CS_GAP - 1) : CW'(CLK_DIV - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Tick marks the last cycle of the loaded interval.
  assign tick = (count == '0);

endmodule

// File: rtl/sprite_spi_master.sv
// Mode-0, MSB-first SPI initiator with a valid/ready byte stream front end.
// Define SPRITE_SPI_FRAME_SYNC_EN to hold each new transaction until a next_frame rising edge.
module sprite_spi_master
  import sprite_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       next_frame,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int              BW       = $clog2(SPI_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(SPI_BITS - 1);

  state_t              state;
  logic [SPI_BITS-1:0] tx_shift;
  logic [SPI_BITS-1:0] rx_shift;
  logic [BW-1:0]       bit_cnt;
  logic                last_q;
  logic                accept;
  logic                load;
  logic                load_gap;
  logic                tick;
  logic                frame_rise;

  assign accept = tx_valid && tx_ready;

`ifdef SPRITE_SPI_FRAME_SYNC_EN
  logic [2:0] frame_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_sync <= '0;
    else       frame_sync <= {frame_sync[1:0], next_frame};
  end

  assign frame_rise = frame_sync[1] && !frame_sync[2];
`else
  logic unused_next_frame;
  assign unused_next_frame = next_frame;
  assign frame_rise        = 1'b0;
`endif

  // Reload the pacing counter on every transition into a timed state.
  always_comb begin
    load     = 1'b0;
    load_gap = 1'b0;
    case (state)
      IDLE, HOLD:                 load = accept;
      WAIT_FRAME:                 load = frame_rise;
      SETUP, SHIFT_LO, SHIFT_HI:  load = tick;
      TEARDOWN: begin
        load     = tick;
        load_gap = tick;
      end
      default:                    load = 1'b0;
    endcase
  end

  sprite_spi_tick #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) u_tick (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .load_gap (load_gap),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      last_q   <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (accept) begin
            tx_shift <= tx_data;
            last_q   <= tx_last;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SPRITE_SPI_FRAME_SYNC_EN
            state    <= WAIT_FRAME;
`else
            spi_cs   <= 1'b0;
            spi_mosi <= tx_data[7];
            state    <= SETUP;
`endif
          end
        end
        WAIT_FRAME: begin
          if (frame_rise) begin
            spi_cs   <= 1'b0;
            spi_mosi <= tx_shift[7];
            state    <= SETUP;
          end
        end
        SETUP, SHIFT_LO: begin
          if (tick) begin
            spi_sclk <= 1'b1;
            rx_shift <= {rx_shift[SPI_BITS-2:0], spi_miso};
            state    <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            spi_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
              if (last_q) begin
                state <= TEARDOWN;
              end else begin
                tx_ready <= 1'b1;
                state    <= HOLD;
              end
            end else begin
              // Rotate so the next bit to send is always at bit 6 before the shift.
              tx_shift <= {tx_shift[SPI_BITS-2:0], tx_shift[SPI_BITS-1]};
              spi_mosi <= tx_shift[SPI_BITS-2];
              state    <= SHIFT_LO;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            tx_shift <= tx_data;
            last_q   <= tx_last;
            tx_ready <= 1'b0;
            spi_mosi <= tx_data[7];
            state    <= SHIFT_LO;
          end
        end
        TEARDOWN: begin
          if (tick) begin
            spi_cs <= 1'b1;
            state  <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_spi_master.sv
// Scoreboard bench for sprite_spi_master with an echoing mode-0 SPI target model.
module tb_sprite_spi_master;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;
  localparam int BIG     = 1000000;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       next_frame;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Target model state: byte list in send order and SCLK falls seen so far.
  logic [7:0] tgt_arr [0:63];
  int         tgt_wr    = 0;
  int         sent_bits = 0;
  logic [7:0] tgt_cur;

  // Observation state updated once per clock at the falling edge.
  int         cyc = 0;
  logic       sclk_prev = 1'b0;
  logic       cs_prev   = 1'b1;
  logic [7:0] mosi_sh   = 8'h00;
  int rises, rx_pulses, cs_rises, cs_falls, gap_ready_bad;
  int last_rise_cyc, last_fall_cyc, cs_rise_cyc, cs_fall_cyc;
  int hi_min, hi_max, per_min, per_max, fr_max, cs_hi_min;

  logic auto_frame = 1'b1;
  logic auto_nf    = 1'b0;
  logic manual_nf  = 1'b0;

  always #5 clk = ~clk;

`ifdef SPRITE_SPI_FRAME_SYNC_EN
  always #400 auto_nf = ~auto_nf;
`endif
  assign next_frame = auto_frame ? auto_nf : manual_nf;

  sprite_spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .next_frame (next_frame),
    .spi_cs     (spi_cs),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  // Target shifts on SCLK falls; a cs rise drops any partial byte.
  always @(negedge spi_sclk or posedge spi_cs) begin
    if (spi_cs === 1'b1)      sent_bits = (sent_bits + 7) / 8 * 8;
    else if (spi_cs === 1'b0) sent_bits = sent_bits + 1;
  end

  always @* begin
    tgt_cur  = tgt_arr[(sent_bits / 8) % 64];
    spi_miso = tgt_cur[7 - (sent_bits % 8)];
  end

  task automatic reset_stats();
    rises = 0; rx_pulses = 0; cs_rises = 0; cs_falls = 0; gap_ready_bad = 0;
    last_rise_cyc = -1; last_fall_cyc = -1; cs_rise_cyc = -1; cs_fall_cyc = -1;
    hi_min = BIG; hi_max = 0; per_min = BIG; per_max = 0; fr_max = 0; cs_hi_min = BIG;
  endtask

  // One clock of observation; scoreboard entries are popped when rx_valid pulses.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (spi_sclk === 1'b1 && sclk_prev === 1'b0 && spi_cs === 1'b0) begin
      if (rises % 8 != 0 && last_rise_cyc >= 0) begin
        if (cyc - last_rise_cyc < per_min) per_min = cyc - last_rise_cyc;
        if (cyc - last_rise_cyc > per_max) per_max = cyc - last_rise_cyc;
      end
      if (last_fall_cyc >= 0 && cyc - last_fall_cyc > fr_max) fr_max = cyc - last_fall_cyc;
      last_rise_cyc = cyc;
      rises++;
      mosi_sh = {mosi_sh[6:0], spi_mosi};
    end
    if (spi_sclk === 1'b0 && sclk_prev === 1'b1 && last_rise_cyc >= 0) begin
      if (cyc - last_rise_cyc < hi_min) hi_min = cyc - last_rise_cyc;
      if (cyc - last_rise_cyc > hi_max) hi_max = cyc - last_rise_cyc;
      last_fall_cyc = cyc;
    end
    if (spi_cs === 1'b1 && cs_prev === 1'b0) begin
      cs_rises++;
      cs_rise_cyc = cyc;
    end
    if (spi_cs === 1'b0 && cs_prev === 1'b1) begin
      cs_falls++;
      cs_fall_cyc   = cyc;
      last_fall_cyc = -1;
      if (cs_rise_cyc >= 0 && cyc - cs_rise_cyc < cs_hi_min) cs_hi_min = cyc - cs_rise_cyc;
    end
    if (spi_cs === 1'b1 && busy === 1'b1 && tx_ready === 1'b1) gap_ready_bad++;
    if (rx_valid === 1'b1) begin
      rx_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rx: got rx_data %02h with nothing expected", rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e.rx) begin
          errors++;
          $display("FAIL rx_data: got %02h expected %02h", rx_data, e.rx);
        end
        checks++;
        if (mosi_sh !== e.tx) begin
          errors++;
          $display("FAIL mosi_byte: got %02h expected %02h", mosi_sh, e.tx);
        end
      end
    end
    sclk_prev = spi_sclk;
    cs_prev   = spi_cs;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] m);
    int n;
    exp_q.push_back('{tx: d, rx: m});
    tgt_arr[tgt_wr % 64] = m;
    tgt_wr++;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL accept_timeout: tx_ready %b after %0d cycles, expected 1", tx_ready, n);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || spi_cs !== 1'b1) && n < 2000) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL idle_timeout: busy %b cs %b, expected 0 1", busy, spi_cs);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    for (int i = 0; i < 64; i++) tgt_arr[i] = 8'h00;
    reset_stats();
    #2 reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({spi_cs, spi_sclk, spi_mosi, tx_ready, rx_valid, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got cs,sclk,mosi,rdy,rxv,busy=%b expected 100000",
               {spi_cs, spi_sclk, spi_mosi, tx_ready, rx_valid, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %02h expected 00", rx_data);
    end
    reset = 1'b0;
    repeat (2) step();
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got ready %b busy %b expected 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_single_byte();
    reset_stats();
    send_byte(8'hA5, 1'b1, 8'h3C);
    wait_idle();
    checks++;
    if (rises !== 8) begin
      errors++;
      $display("FAIL single_rises: got %0d expected 8", rises);
    end
    checks++;
    if (hi_min !== CLK_DIV || hi_max !== CLK_DIV) begin
      errors++;
      $display("FAIL sclk_high: got %0d..%0d expected %0d", hi_min, hi_max, CLK_DIV);
    end
    checks++;
    if (per_min !== 2 * CLK_DIV || per_max !== 2 * CLK_DIV) begin
      errors++;
      $display("FAIL sclk_period: got %0d..%0d expected %0d", per_min, per_max, 2 * CLK_DIV);
    end
    checks++;
    if (rx_pulses !== 1) begin
      errors++;
      $display("FAIL single_rx_pulses: got %0d expected 1", rx_pulses);
    end
    checks++;
    if (cs_rise_cyc - last_fall_cyc !== CLK_DIV) begin
      errors++;
      $display("FAIL teardown_len: got %0d expected %0d", cs_rise_cyc - last_fall_cyc, CLK_DIV);
    end
  endtask

  task automatic test_back_to_back();
    reset_stats();
    send_byte(8'h01, 1'b0, 8'hC1);
    send_byte(8'h02, 1'b0, 8'h82);
    send_byte(8'h03, 1'b1, 8'h43);
    wait_idle();
    checks++;
    if (rises !== 24 || rx_pulses !== 3) begin
      errors++;
      $display("FAIL b2b_counts: got rises %0d rx %0d expected 24 3", rises, rx_pulses);
    end
    checks++;
    if (cs_falls !== 1 || cs_rises !== 1) begin
      errors++;
      $display("FAIL b2b_cs: got falls %0d rises %0d expected 1 1", cs_falls, cs_rises);
    end
    checks++;
    if (fr_max !== CLK_DIV + 1) begin
      errors++;
      $display("FAIL b2b_inter_byte: got %0d expected %0d", fr_max, CLK_DIV + 1);
    end
  endtask

  task automatic test_hold_stall();
    int n;
    int bad;
    reset_stats();
    send_byte(8'h10, 1'b0, 8'h81);
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (spi_cs !== 1'b0 || spi_sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    checks++;
    if (n >= 200 || bad !== 0) begin
      errors++;
      $display("FAIL hold_stall: got %0d bad cycles (wait %0d) expected 0", bad, n);
    end
    send_byte(8'hFF, 1'b1, 8'h5A);
    wait_idle();
    checks++;
    if (rises !== 16 || rx_pulses !== 2 || cs_rises !== 1) begin
      errors++;
      $display("FAIL hold_counts: got rises %0d rx %0d cs_rises %0d expected 16 2 1",
               rises, rx_pulses, cs_rises);
    end
  endtask

  task automatic test_two_transactions();
    reset_stats();
    send_byte(8'hAA, 1'b1, 8'h55);
    send_byte(8'h0F, 1'b1, 8'hF0);
    wait_idle();
    checks++;
    if (cs_hi_min < CS_GAP || cs_hi_min == BIG || cs_falls !== 2) begin
      errors++;
      $display("FAIL cs_gap: got %0d cycles high (falls %0d) expected >= %0d", cs_hi_min, cs_falls, CS_GAP);
    end
    checks++;
    if (gap_ready_bad !== 0) begin
      errors++;
      $display("FAIL gap_ready: got %0d ready cycles in gap expected 0", gap_ready_bad);
    end
    checks++;
    if (rx_pulses !== 2) begin
      errors++;
      $display("FAIL two_txn_rx: got %0d expected 2", rx_pulses);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    exp_t dropped;
    reset_stats();
    send_byte(8'hC3, 1'b1, 8'h99);
    n = 0;
    while (rises < 3 && n < 200) begin
      step();
      n++;
    end
    pulses = rx_pulses;
    reset  = 1'b1;
    #1;
    checks++;
    if (n >= 200 || {spi_cs, spi_sclk, rx_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid: got cs,sclk,rxv,busy=%b expected 1000", {spi_cs, spi_sclk, rx_valid, busy});
    end
    dropped = exp_q.pop_front();
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (rx_pulses !== pulses) begin
      errors++;
      $display("FAIL reset_no_rx: got %0d pulses expected %0d (dropped %02h)", rx_pulses, pulses, dropped.tx);
    end
    reset_stats();
    send_byte(8'h3E, 1'b1, 8'hE7);
    wait_idle();
    checks++;
    if (rises !== 8 || rx_pulses !== 1) begin
      errors++;
      $display("FAIL post_reset_byte: got rises %0d rx %0d expected 8 1", rises, rx_pulses);
    end
  endtask

`ifdef SPRITE_SPI_FRAME_SYNC_EN
  task automatic test_frame_sync();
    int n;
    int bad;
    int edge_cyc;
    auto_frame = 1'b0;
    manual_nf  = 1'b0;
    repeat (4) step();
    reset_stats();
    send_byte(8'h66, 1'b1, 8'h18);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (spi_cs !== 1'b1 || busy !== 1'b1) bad++;
    end
    manual_nf = 1'b1;
    edge_cyc  = cyc;
    n = 0;
    while (spi_cs !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bad !== 0 || cs_fall_cyc - edge_cyc < 3 || cs_fall_cyc - edge_cyc > 4) begin
      errors++;
      $display("FAIL frame_latency: got %0d cycles (early %0d) expected 3..4", cs_fall_cyc - edge_cyc, bad);
    end
    repeat (3) step();
    manual_nf = 1'b0;
    repeat (4) step();
    manual_nf = 1'b1;
    wait_idle();
    send_byte(8'h77, 1'b1, 8'h24);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (spi_cs !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL frame_not_queued: got %0d cs-low cycles expected 0", bad);
    end
    manual_nf = 1'b0;
    repeat (3) step();
    manual_nf = 1'b1;
    wait_idle();
    checks++;
    if (rx_pulses !== 2 || cs_falls !== 2) begin
      errors++;
      $display("FAIL frame_counts: got rx %0d falls %0d expected 2 2", rx_pulses, cs_falls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_hold_stall();
    test_two_transactions();
    test_reset_mid();
`ifdef SPRITE_SPI_FRAME_SYNC_EN
    test_frame_sync();
`endif
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
